// File: rtl/axi4_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// axi4_sram_responder_pkg
// Shared definitions for the AXI4 SRAM responder: response codes and the
// read/write channel FSM state encodings.
// -----------------------------------------------------------------------------
package axi4_sram_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

endpackage

// File: rtl/axi4_sram_responder_if.sv
// -----------------------------------------------------------------------------
// axi4_sram_responder_if
// AXI4 bus bundle between the core's io_master port and the SRAM responder.
//   AR/R : araddr, arlen, arid, arvalid / arready_o, rdata_o, rresp_o, rid_o,
//          rlast_o, rvalid_o / rready
//   AW/W/B : awaddr, awlen, awid, awvalid / awready_o, wdata, wstrb, wlast,
//            wvalid / wready_o, bresp_o, bid_o, bvalid_o / bready
// Modports: slave (the responder) and master (the requester).
// -----------------------------------------------------------------------------
interface axi4_sram_responder_if;

  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [3:0]  arid;
  logic        arvalid;
  logic        arready_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic [3:0]  rid_o;
  logic        rlast_o;
  logic        rvalid_o;
  logic        rready;

  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [3:0]  awid;
  logic        awvalid;
  logic        awready_o;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready_o;
  logic [1:0]  bresp_o;
  logic [3:0]  bid_o;
  logic        bvalid_o;
  logic        bready;

  modport slave (
    input  araddr, arlen, arid, arvalid, rready,
    output arready_o, rdata_o, rresp_o, rid_o, rlast_o, rvalid_o,
    input  awaddr, awlen, awid, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready_o, wready_o, bresp_o, bid_o, bvalid_o
  );

  modport master (
    output araddr, arlen, arid, arvalid, rready,
    input  arready_o, rdata_o, rresp_o, rid_o, rlast_o, rvalid_o,
    output awaddr, awlen, awid, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready_o, wready_o, bresp_o, bid_o, bvalid_o
  );

endinterface

// File: rtl/axi4_sram_responder_delay_lfsr.sv
// -----------------------------------------------------------------------------
// axi4_delay_lfsr
// Free-running 20-bit LFSR plus a 3-bit wait-cycle down-counter.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load the counter with lfsr[2:0] (or 0 when delays are off)
//   expired   : counter has reached zero
// The LFSR advances every cycle regardless of load, so consecutive loads see
// different delay values.
// -----------------------------------------------------------------------------
module axi4_delay_lfsr #(
  parameter int unsigned DELAY_EN  = 0,
  parameter logic [19:0] LFSR_SEED = 20'h1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  logic [19:0] lfsr_q, lfsr_d;
  logic [2:0]  cnt_q, cnt_d;

  always_comb begin
    lfsr_d = {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[18]};
    cnt_d  = cnt_q;
    if (load) begin
      cnt_d = (DELAY_EN != 0) ? lfsr_q[2:0] : 3'd0;
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      cnt_q  <= 3'd0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign expired = (cnt_q == 3'd0);

endmodule

// File: rtl/axi4_sram_responder.sv
// -----------------------------------------------------------------------------
// axi4_sram_responder
// AXI4 slave memory model: a 2^MEM_AW x 64-bit word array behind independent
// read and write channel FSMs, INCR bursts with an 8-byte stride, byte-strobe
// merging, SLVERR for addresses outside the window, and optional random wait
// cycles ahead of each data phase.
//   clk, rst : clock, synchronous active-high reset
//   bus      : AXI4 slave modport (AR/R and AW/W/B channels)
// -----------------------------------------------------------------------------
module axi4_sram_responder
  import axi4_sram_responder_pkg::*;
#(
  parameter int unsigned MEM_AW    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DELAY_EN  = 0,
  parameter logic [19:0] LFSR_SEED = 20'h1
) (
  input  logic                 clk,
  input  logic                 rst,
  axi4_sram_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  // Word number relative to the window base; anything with bits above MEM_AW
  // set lies outside the window (addresses below the base wrap to huge values).
  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return (addr - BASE_ADDR) >> 3;
  endfunction

  logic [63:0] mem [DEPTH];
  logic [63:0] rd_word_q;

  // Read channel state
  r_state_e    r_state_q, r_state_d;
  logic [31:0] raddr_q, raddr_d;
  logic [7:0]  rlen_q, rlen_d;
  logic [3:0]  rid_q, rid_d;
  logic [7:0]  rbeat_q, rbeat_d;
  logic        rerr_q, rerr_d;

  // Write channel state
  w_state_e    w_state_q, w_state_d;
  logic [31:0] waddr_q, waddr_d;
  logic [7:0]  wlen_q, wlen_d;
  logic [3:0]  wid_q, wid_d;
  logic [7:0]  wbeat_q, wbeat_d;
  logic        werr_q, werr_d;

  logic              r_load, w_load;
  logic [1:0]        dly_load, dly_expired;
  logic              rd_en, wr_en;
  logic [31:0]       r_word, w_word;
  logic              r_in_win, w_in_win;
  logic [MEM_AW-1:0] r_idx, w_idx;
  logic              w_fire, w_end;

  // Channel 0 = read, channel 1 = write; each gets its own delay source.
  assign dly_load = {w_load, r_load};

  for (genvar gi = 0; gi < 2; gi++) begin : g_dly
    axi4_delay_lfsr #(
      .DELAY_EN  (DELAY_EN),
      .LFSR_SEED (LFSR_SEED)
    ) u_dly (
      .clk     (clk),
      .rst     (rst),
      .load    (dly_load[gi]),
      .expired (dly_expired[gi])
    );
  end

  assign r_word   = word_of(raddr_q);
  assign r_in_win = ((r_word >> MEM_AW) == 32'd0);
  assign r_idx    = r_word[MEM_AW-1:0];
  assign w_word   = word_of(waddr_q);
  assign w_in_win = ((w_word >> MEM_AW) == 32'd0);
  assign w_idx    = w_word[MEM_AW-1:0];

  // ---------------------------------------------------------------- read FSM
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rid_d     = rid_q;
    rbeat_d   = rbeat_q;
    rerr_d    = rerr_q;
    r_load    = 1'b0;
    rd_en     = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (bus.arvalid) begin
          raddr_d   = bus.araddr;
          rlen_d    = bus.arlen;
          rid_d     = bus.arid;
          rbeat_d   = 8'd0;
          r_load    = 1'b1;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (dly_expired[0]) begin
          rd_en     = 1'b1;
          rerr_d    = !r_in_win;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (bus.rready) begin
          if (rbeat_q == rlen_q) begin
            r_state_d = R_IDLE;
          end else begin
            raddr_d   = raddr_q + 32'd8;
            rbeat_d   = rbeat_q + 8'd1;
            r_load    = 1'b1;
            r_state_d = R_WAIT;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // --------------------------------------------------------------- write FSM
  assign w_fire = (w_state_q == W_DATA) && bus.wvalid && dly_expired[1];
  assign w_end  = bus.wlast || (wbeat_q == wlen_q);

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wid_d     = wid_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    w_load    = 1'b0;
    wr_en     = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (bus.awvalid) begin
          waddr_d   = bus.awaddr;
          wlen_d    = bus.awlen;
          wid_d     = bus.awid;
          wbeat_d   = 8'd0;
          werr_d    = 1'b0;
          w_load    = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          if (w_in_win) begin
            wr_en = !rst;
          end else begin
            werr_d = 1'b1;
          end
          waddr_d = waddr_q + 32'd8;
          wbeat_d = wbeat_q + 8'd1;
          if (w_end) begin
            // wlast disagreeing with the announced length is a protocol error.
            if (bus.wlast != (wbeat_q == wlen_q)) begin
              werr_d = 1'b1;
            end
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      raddr_q   <= 32'd0;
      rlen_q    <= 8'd0;
      rid_q     <= 4'd0;
      rbeat_q   <= 8'd0;
      rerr_q    <= 1'b0;
      w_state_q <= W_IDLE;
      waddr_q   <= 32'd0;
      wlen_q    <= 8'd0;
      wid_q     <= 4'd0;
      wbeat_q   <= 8'd0;
      werr_q    <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rid_q     <= rid_d;
      rbeat_q   <= rbeat_d;
      rerr_q    <= rerr_d;
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wid_q     <= wid_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
    end
  end

  // Word array: byte-lane writes plus a registered read port. Both sit in one
  // process so a same-cycle read of the word being written returns old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.wstrb[b]) begin
          mem[w_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
        end
      end
    end
    if (rd_en && !rst) begin
      rd_word_q <= mem[r_idx];
    end
  end

  // Outputs decode from registered state; rd_word_q only changes in R_WAIT,
  // so R beats stay stable while the master stalls.
  assign bus.arready_o = (r_state_q == R_IDLE);
  assign bus.rvalid_o  = (r_state_q == R_DATA);
  assign bus.rdata_o   = (bus.rvalid_o && !rerr_q) ? rd_word_q : 64'd0;
  assign bus.rresp_o   = (bus.rvalid_o && rerr_q) ? RESP_SLVERR : RESP_OKAY;
  assign bus.rid_o     = bus.rvalid_o ? rid_q : 4'd0;
  assign bus.rlast_o   = bus.rvalid_o && (rbeat_q == rlen_q);

  assign bus.awready_o = (w_state_q == W_IDLE);
  assign bus.wready_o  = (w_state_q == W_DATA) && dly_expired[1];
  assign bus.bvalid_o  = (w_state_q == W_RESP);
  assign bus.bresp_o   = (bus.bvalid_o && werr_q) ? RESP_SLVERR : RESP_OKAY;
  assign bus.bid_o     = bus.bvalid_o ? wid_q : 4'd0;

endmodule

// File: tb/tb_axi4_sram_responder.sv
module tb_axi4_sram_responder;
  import axi4_sram_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_sram_responder_if bus();

  axi4_sram_responder #(
    .MEM_AW    (12),
    .BASE_ADDR (32'h8000_0000),
    .DELAY_EN  (1),
    .LFSR_SEED (20'h1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] wbuf  [32];
  logic [7:0]  sbuf  [32];
  logic [63:0] ebuf  [32];
  logic [1:0]  erbuf [32];
  logic [63:0] model [32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    int n;
    n = 0;
    bus.awaddr = a; bus.awlen = l; bus.awid = id; bus.awvalid = 1'b1;
    while (!bus.awready_o && n < 50) begin tick(); n++; end
    chk("awready", 64'(bus.awready_o), 64'd1);
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic last);
    int n;
    n = 0;
    bus.wdata = d; bus.wstrb = s; bus.wlast = last; bus.wvalid = 1'b1;
    while (!bus.wready_o && n < 50) begin tick(); n++; end
    chk("wready", 64'(bus.wready_o), 64'd1);
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic get_b(input logic [1:0] er, input logic [3:0] eid);
    int n;
    n = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid_o && n < 50) begin tick(); n++; end
    chk("bvalid", 64'(bus.bvalid_o), 64'd1);
    chk("bresp", 64'(bus.bresp_o), 64'(er));
    chk("bid", 64'(bus.bid_o), 64'(eid));
    tick();
    bus.bready = 1'b0;
  endtask

  // Beats 0..last_at come from wbuf/sbuf; wlast is raised on beat last_at.
  task automatic wr_burst(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id,
                          input int last_at, input logic [1:0] er);
    send_aw(a, l, id);
    for (int i = 0; i <= last_at; i++) send_w(wbuf[i], sbuf[i], i == last_at);
    chk("bvalid_next", 64'(bus.bvalid_o), 64'd1);
    get_b(er, id);
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    int n;
    n = 0;
    bus.araddr = a; bus.arlen = l; bus.arid = id; bus.arvalid = 1'b1;
    while (!bus.arready_o && n < 50) begin tick(); n++; end
    chk("arready", 64'(bus.arready_o), 64'd1);
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic get_r(input logic [7:0] l, input logic [3:0] id);
    int n;
    for (int i = 0; i <= int'(l); i++) begin
      n = 0;
      repeat ($urandom_range(0, 2)) tick();
      bus.rready = 1'b1;
      while (!bus.rvalid_o && n < 50) begin tick(); n++; end
      chk("rvalid", 64'(bus.rvalid_o), 64'd1);
      chk("rdata", bus.rdata_o, ebuf[i]);
      chk("rresp", 64'(bus.rresp_o), 64'(erbuf[i]));
      chk("rid", 64'(bus.rid_o), 64'(id));
      chk("rlast", 64'(bus.rlast_o), 64'(i == int'(l)));
      tick();
      bus.rready = 1'b0;
    end
  endtask

  task automatic rd_burst(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    send_ar(a, l, id);
    get_r(l, id);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_arready"}, 64'(bus.arready_o), 64'd1);
    chk({tag, "_awready"}, 64'(bus.awready_o), 64'd1);
    chk({tag, "_rvalid"}, 64'(bus.rvalid_o), 64'd0);
    chk({tag, "_bvalid"}, 64'(bus.bvalid_o), 64'd0);
    chk({tag, "_wready"}, 64'(bus.wready_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wo, wl, ro, rl, wb, rb;
    bus.araddr = '0; bus.arlen = '0; bus.arid = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awlen = '0; bus.awid = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;

    // 1. Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_idle("reset");

    // 2. Full write, half-strobe overwrite, read back from an unaligned address
    wbuf[0] = 64'h1122334455667788; sbuf[0] = 8'hFF;
    wr_burst(32'h8000_0008, 8'd0, 4'd1, 0, RESP_OKAY);
    wbuf[0] = 64'hAAAAAAAA_BBBBBBBB; sbuf[0] = 8'h0F;
    wr_burst(32'h8000_0008, 8'd0, 4'd1, 0, RESP_OKAY);
    ebuf[0] = 64'h11223344_BBBBBBBB; erbuf[0] = RESP_OKAY;
    rd_burst(32'h8000_000C, 8'd0, 4'd2);

    // 3. Four-beat burst write and read
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 64'(i + 1); sbuf[i] = 8'hFF; ebuf[i] = 64'(i + 1); erbuf[i] = RESP_OKAY;
    end
    wr_burst(32'h8000_0100, 8'd3, 4'd3, 3, RESP_OKAY);
    rd_burst(32'h8000_0100, 8'd3, 4'd5);

    // 4. Backpressure: R beat held, next AR refused while stalled
    send_ar(32'h8000_0100, 8'd0, 4'd2);
    begin
      int n;
      n = 0;
      while (!bus.rvalid_o && n < 50) begin tick(); n++; end
    end
    bus.araddr = 32'h8000_0108; bus.arlen = 8'd0; bus.arid = 4'd3; bus.arvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_rvalid", 64'(bus.rvalid_o), 64'd1);
      chk("bp_rdata", bus.rdata_o, 64'd1);
      chk("bp_arready", 64'(bus.arready_o), 64'd0);
      tick();
    end
    bus.rready = 1'b1;
    chk("bp_rdata_hs", bus.rdata_o, 64'd1);
    tick();
    bus.rready = 1'b0;
    ebuf[0] = 64'd2; erbuf[0] = RESP_OKAY;
    rd_burst(32'h8000_0108, 8'd0, 4'd3);

    // 5. Error cases and window edges
    ebuf[0] = 64'd0; erbuf[0] = RESP_SLVERR;
    rd_burst(32'h1000_0000, 8'd0, 4'd4);
    wbuf[0] = 64'h55; sbuf[0] = 8'hFF;
    wr_burst(32'h8000_0200, 8'd1, 4'd6, 0, RESP_SLVERR);
    wbuf[0] = 64'hDEADBEEF_DEADBEEF; sbuf[0] = 8'hFF;
    wr_burst(32'h8000_8008, 8'd0, 4'd7, 0, RESP_SLVERR);
    ebuf[0] = 64'h11223344_BBBBBBBB; erbuf[0] = RESP_OKAY;
    rd_burst(32'h8000_0008, 8'd0, 4'd7);
    wbuf[0] = 64'h01234567_89ABCDEF; sbuf[0] = 8'hFF;
    wr_burst(32'h8000_7FF8, 8'd0, 4'd8, 0, RESP_OKAY);
    ebuf[0] = 64'h01234567_89ABCDEF; erbuf[0] = RESP_OKAY;
    ebuf[1] = 64'd0;                 erbuf[1] = RESP_SLVERR;
    rd_burst(32'h8000_7FF8, 8'd1, 4'd9);

    // 6. Concurrent random traffic on disjoint halves of a 32-word region
    for (int i = 0; i < 32; i++) begin
      wbuf[i] = {$urandom(), $urandom()}; sbuf[i] = 8'hFF; model[i] = wbuf[i];
    end
    wr_burst(32'h8000_1000, 8'd31, 4'd1, 31, RESP_OKAY);
    for (int it = 0; it < 16; it++) begin
      wb = (it % 2 == 1) ? 0 : 16;
      rb = (it % 2 == 1) ? 16 : 0;
      wo = $urandom_range(0, 12); wl = $urandom_range(0, 3);
      ro = $urandom_range(0, 12); rl = $urandom_range(0, 3);
      for (int i = 0; i <= rl; i++) begin
        ebuf[i] = model[rb + ro + i]; erbuf[i] = RESP_OKAY;
      end
      for (int i = 0; i <= wl; i++) begin
        wbuf[i] = {$urandom(), $urandom()}; sbuf[i] = 8'($urandom());
        for (int b = 0; b < 8; b++)
          if (sbuf[i][b]) model[wb + wo + i][b*8 +: 8] = wbuf[i][b*8 +: 8];
      end
      fork
        wr_burst(32'h8000_1000 + 32'((wb + wo) * 8), 8'(wl), 4'(it), wl, RESP_OKAY);
        rd_burst(32'h8000_1000 + 32'((rb + ro) * 8), 8'(rl), 4'(15 - it));
      join
    end
    for (int i = 0; i < 32; i++) begin
      ebuf[i] = model[i]; erbuf[i] = RESP_OKAY;
    end
    rd_burst(32'h8000_1000, 8'd31, 4'd10);

    // Reset in the middle of a write burst and a read burst
    fork
      begin
        send_aw(32'h8000_2000, 8'd3, 4'd2);
        send_w(64'h1, 8'hFF, 1'b0);
      end
      send_ar(32'h8000_1000, 8'd3, 4'd3);
    join
    tick();
    rst = 1'b1;
    tick(); tick();
    chk_idle("midrst_in");
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_idle("midrst_out");
    end
    wbuf[0] = 64'hCAFEF00D_12345678; sbuf[0] = 8'hFF;
    wr_burst(32'h8000_2000, 8'd0, 4'd1, 0, RESP_OKAY);
    ebuf[0] = 64'hCAFEF00D_12345678; erbuf[0] = RESP_OKAY;
    rd_burst(32'h8000_2000, 8'd0, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
